fsm_phase_seq: RTL and testbench
================================

// Module: fsm_phase_seq
// PURPOSE
//  Parametrised multi-phase timed sequencer; successor to the fixed 4-state one-hot sequencer.
//  Fixed states/16-cycle dwell generalised to NUM_PHASES phases, each with its own dwell and output pattern.
//  Adds abort, loop mode, busy/done status; config is latched at start.
//  Drives control strobes to downstream datapath blocks from a single start pulse.
// PARAMETERS
//  NUM_PHASES  3  number of active phases (1..2**IDX_W)
//  CNT_W       4  dwell counter width; phase i lasts phase_len[i]+1 cycles
//  OUT_W       2  width of per-phase output pattern
//  IDX_W       2  width of phase_idx
// PORTS
//  clk        in   1                   system clock, rising edge
//  rst_n      in   1                   async active-low reset
//  jump       in   1                   start request, sampled in IDLE only
//  abort      in   1                   terminate run, return to IDLE
//  loop_en    in   1                   1: restart phase 0 after last phase instead of finishing
//  phase_len  in   NUM_PHASES*CNT_W    dwell per phase; phase i at [i*CNT_W +: CNT_W]
//  phase_pat  in   NUM_PHASES*OUT_W    output per phase; phase i at [i*OUT_W +: OUT_W]
//  dout       out  OUT_W               registered pattern of current phase; 0 outside RUN
//  phase_idx  out  IDX_W               current phase index; 0 outside RUN
//  busy       out  1                   1 while in RUN
//  done       out  1                   1-cycle pulse on normal completion
// BEHAVIOUR
//  - Reset (async, any time incl. mid-run): state=IDLE, cnt=0, phase_idx=0, dout=0, busy=0, done=0,
//    latched config=0. Run is lost; no done pulse.
//  - States: IDLE, RUN, DONE; two-process FSM (state register, combinational next-state).
//    All outputs are registered, decoded from next state, so they align with the state register.
//  - IDLE: jump=1 at edge N latches phase_len/phase_pat. From N+1: RUN, phase 0, cnt=0,
//    dout=pat[0], busy=1.
//  - RUN: cnt increments each cycle. When cnt==len[idx], this is the last cycle of the phase.
//    Next cycle: cnt=0, idx+1, dout=pat[idx+1].
//  - End of last phase (idx==NUM_PHASES-1, cnt==len):
//    - loop_en=1: next cycle idx=0, dout=pat[0], still RUN, no done.
//    - loop_en=0: next cycle DONE: done=1, busy=0, dout=0. The cycle after: IDLE.
//    - loop_en is sampled only at this boundary.
//  - abort=1 in RUN: next cycle IDLE, dout=0, busy=0, done=0.
//    abort wins over phase advance and completion. abort in IDLE or DONE is ignored.
//  - jump in RUN or DONE is ignored; no queuing. jump and abort together in IDLE: start is taken.
//  - phase_len/phase_pat changes after start have no effect until the next start, including looped passes.
//  - len=0: one-cycle phase. Max len=2**CNT_W-1 gives 2**CNT_W cycles; cnt never wraps past len.
//  - Illegal state encoding: next state is IDLE.
// TESTING
//  1 Defaults, len={15,15,15}, pat={01,10,11}, jump pulse at edge 0 ->
//    dout=01 cycles 1-16, 10 cycles 17-32, 11 cycles 33-48; done=1 at cycle 49; IDLE at 50.
//  2 len={0,2,0}, pat={11,01,10} -> dout 11 (1 cycle), 01 (3 cycles), 10 (1 cycle), then done pulse.
//  3 loop_en=1, len={1,1,1} -> pattern repeats with period 6, no done. Drop loop_en ->
//    done follows the next phase-2 end.
//  4 abort at cycle 20 of test 1 -> dout=0, busy=0 at cycle 21; no done.
//    Abort coincident with last-cycle completion also gives no done.
//  5 jump pulses during RUN and DONE, and phase_len rewritten mid-run ->
//    timing identical to test 1; single done.
//  6 rst_n low at cycle 25 of test 1 -> all outputs 0 immediately.
//    After release, jump restarts cleanly from phase 0.

Source files
------------

// File: rtl/fsm_phase_seq.sv
// Multi-phase timed sequencer: a start pulse runs NUM_PHASES phases, each with its own
// dwell and output pattern latched at start, with optional looping and abort.
module fsm_phase_seq #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 4,
    parameter int OUT_W      = 2,
    parameter int IDX_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        jump,
    input  logic                        abort,
    input  logic                        loop_en,
    input  logic [NUM_PHASES*CNT_W-1:0] phase_len,
    input  logic [NUM_PHASES*OUT_W-1:0] phase_pat,
    output logic [OUT_W-1:0]            dout,
    output logic [IDX_W-1:0]            phase_idx,
    output logic                        busy,
    output logic                        done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLOTS = 2**IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_nxt;
    logic [IDX_W-1:0]            idx_nxt;
    logic [NUM_PHASES*CNT_W-1:0] len_q;
    logic [NUM_PHASES*OUT_W-1:0] pat_q;
    logic [NUM_PHASES*OUT_W-1:0] pat_src;
    logic [CNT_W-1:0]            len_arr [SLOTS];
    logic [OUT_W-1:0]            pat_arr [SLOTS];
    logic                        phase_end;

    // On the start edge the config is not latched yet, so phase 0's pattern comes from the inputs.
    assign pat_src = (state == IDLE) ? phase_pat : pat_q;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            len_arr[i] = '0;
            pat_arr[i] = '0;
        end
        for (int i = 0; i < NUM_PHASES; i++) begin
            len_arr[i] = len_q[i*CNT_W +: CNT_W];
            pat_arr[i] = pat_src[i*OUT_W +: OUT_W];
        end
    end

    assign phase_end = (cnt == len_arr[phase_idx]);

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        case (state)
            IDLE: begin
                if (jump) state_nxt = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!phase_end) begin
                    state_nxt = RUN;
                    cnt_nxt   = cnt + CNT_W'(1);
                    idx_nxt   = phase_idx;
                end else if (phase_idx != LAST_IDX) begin
                    state_nxt = RUN;
                    idx_nxt   = phase_idx + IDX_W'(1);
                end else if (loop_en) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            phase_idx <= '0;
            dout      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            pat_q     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            phase_idx <= idx_nxt;
            busy      <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
            dout      <= (state_nxt == RUN) ? pat_arr[idx_nxt] : '0;
            if (state == IDLE && jump) begin
                len_q <= phase_len;
                pat_q <= phase_pat;
            end
        end
    end
endmodule

// File: tb/tb_fsm_phase_seq.sv
// Bench for fsm_phase_seq: expected output traces are expanded from the phase table
// (dwell len+1 cycles per phase) and compared cycle by cycle against the outputs.
module tb_fsm_phase_seq;
    localparam int NP = 3;
    localparam int CW = 4;
    localparam int OW = 2;
    localparam int IW = 2;
    localparam int W  = 2 + IW + OW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              jump = 1'b0;
    logic              abort = 1'b0;
    logic              loop_en = 1'b0;
    logic [NP*CW-1:0]  phase_len = '0;
    logic [NP*OW-1:0]  phase_pat = '0;
    logic [OW-1:0]     dout;
    logic [IW-1:0]     phase_idx;
    logic              busy;
    logic              done;
    logic [W-1:0]      obs;
    logic [W-1:0]      e;
    logic [W-1:0]      exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                n;

    localparam logic [NP*CW-1:0] LEN_T1 = {4'd15, 4'd15, 4'd15};
    localparam logic [NP*OW-1:0] PAT_T1 = {2'b11, 2'b10, 2'b01};

    fsm_phase_seq #(.NUM_PHASES(NP), .CNT_W(CW), .OUT_W(OW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .jump(jump), .abort(abort), .loop_en(loop_en),
        .phase_len(phase_len), .phase_pat(phase_pat),
        .dout(dout), .phase_idx(phase_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {done, busy, phase_idx, dout};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each phase shows its pattern for len+1 cycles; completion adds one done cycle then idle.
    task automatic build_run(input logic [NP*CW-1:0] len, input logic [NP*OW-1:0] pat,
                             input int passes, input bit finish);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < NP; i++)
                for (int c = 0; c <= int'(len[i*CW +: CW]); c++)
                    exp_q.push_back({1'b0, 1'b1, IW'(i), pat[i*OW +: OW]});
        if (finish) begin
            exp_q.push_back({1'b1, 1'b0, {IW{1'b0}}, {OW{1'b0}}});
            exp_q.push_back('0);
        end
    endtask

    task automatic start(input logic [NP*CW-1:0] len, input logic [NP*OW-1:0] pat);
        phase_len = len;
        phase_pat = pat;
        jump = 1'b1;
        step();
        jump = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        phase_len = LEN_T1;
        phase_pat = PAT_T1;
        jump = 1'b1;
        #23;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_hold got %b expected %b", obs, '0); end
        jump = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_release got %b expected %b", obs, '0); end
    endtask

    task automatic test_basic();
        exp_q.delete();
        build_run(LEN_T1, PAT_T1, 1, 1'b1);
        start(LEN_T1, PAT_T1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL basic cycle %0d got %b expected %b", c, obs, e); end
            step();
        end
    endtask

    task automatic test_short();
        logic [NP*CW-1:0] len;
        logic [NP*OW-1:0] pat;
        len = {4'd0, 4'd2, 4'd0};
        pat = {2'b10, 2'b01, 2'b11};
        exp_q.delete();
        build_run(len, pat, 1, 1'b1);
        start(len, pat);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL short cycle %0d got %b expected %b", c, obs, e); end
            step();
        end
    endtask

    task automatic test_random();
        logic [NP*CW-1:0] len;
        logic [NP*OW-1:0] pat;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NP; i++) begin
                case ($urandom_range(0, 3))
                    0:       len[i*CW +: CW] = '0;
                    1:       len[i*CW +: CW] = '1;
                    default: len[i*CW +: CW] = CW'($urandom_range(0, 15));
                endcase
                pat[i*OW +: OW] = OW'($urandom_range(0, 3));
            end
            exp_q.delete();
            build_run(len, pat, 1, 1'b1);
            start(len, pat);
            n = exp_q.size();
            for (int c = 1; c <= n; c++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL random run %0d cycle %0d got %b expected %b", r, c, obs, e);
                end
                step();
            end
        end
    endtask

    task automatic test_loop();
        logic [NP*CW-1:0] len;
        logic [NP*OW-1:0] pat;
        len = {4'd1, 4'd1, 4'd1};
        pat = NP*OW'($urandom_range(0, 63));
        loop_en = 1'b1;
        exp_q.delete();
        build_run(len, pat, 3, 1'b0);
        start(len, pat);
        for (int c = 1; c <= 18; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL loop cycle %0d got %b expected %b", c, obs, e); end
            step();
        end
        loop_en = 1'b0;
        build_run(len, pat, 1, 1'b1);
        n = exp_q.size();
        for (int c = 19; c < 19 + n; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL loop_exit cycle %0d got %b expected %b", c, obs, e); end
            step();
        end
    endtask

    task automatic test_abort();
        logic [NP*CW-1:0] len;
        exp_q.delete();
        build_run(LEN_T1, PAT_T1, 1, 1'b0);
        start(LEN_T1, PAT_T1);
        for (int c = 1; c <= 20; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL abort_pre cycle %0d got %b expected %b", c, obs, e); end
            if (c == 20) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        for (int c = 21; c <= 23; c++) begin
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL abort_post cycle %0d got %b expected %b", c, obs, '0); end
            step();
        end
        // jump with abort in IDLE starts; abort in the final cycle suppresses done
        len = '0;
        exp_q.delete();
        build_run(len, PAT_T1, 1, 1'b0);
        abort = 1'b1;
        start(len, PAT_T1);
        for (int c = 1; c <= 3; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL abort_last cycle %0d got %b expected %b", c, obs, e); end
            if (c == 3) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL abort_nodone cycle %0d got %b expected %b", c, obs, '0); end
            step();
        end
    endtask

    task automatic test_ignore();
        exp_q.delete();
        build_run(LEN_T1, PAT_T1, 1, 1'b1);
        exp_q.push_back('0);
        start(LEN_T1, PAT_T1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL ignore cycle %0d got %b expected %b", c, obs, e); end
            jump = (c < 49) ? ($urandom_range(0, 3) == 0) : (c == 49);
            if (c == 10) begin
                phase_len = NP*CW'($urandom);
                phase_pat = NP*OW'($urandom);
            end
            step();
        end
        jump = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [NP*CW-1:0] len;
        logic [NP*OW-1:0] pat;
        exp_q.delete();
        build_run(LEN_T1, PAT_T1, 1, 1'b0);
        start(LEN_T1, PAT_T1);
        for (int c = 1; c <= 25; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rst_pre cycle %0d got %b expected %b", c, obs, e); end
            if (c < 25) step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL rst_async got %b expected %b", obs, '0); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL rst_idle got %b expected %b", obs, '0); end
        len = {4'd0, 4'd2, 4'd0};
        pat = {2'b10, 2'b01, 2'b11};
        exp_q.delete();
        build_run(len, pat, 1, 1'b1);
        start(len, pat);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rst_restart cycle %0d got %b expected %b", c, obs, e); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_random();
        test_loop();
        test_abort();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
